// File: rtl/audio_packet_pkg.sv
// Shared constants, subpacket type and parity helper for the HDMI audio sample packet path.
package audio_packet_pkg;

  localparam logic [7:0] HB0                = 8'h02;
  localparam int         IEC60958_FRAME_LEN = 192;

  typedef logic [55:0] subpacket_t;

  function automatic logic even_parity(input logic [23:0] data, input logic v,
                                       input logic u, input logic c);
    return ^{data, v, u, c};
  endfunction

endpackage

// File: rtl/audio_subpacket_format.sv
// Formats one stereo sample into a 56-bit audio subpacket: left-aligned data plus VUCP byte.
module audio_subpacket_format
  import audio_packet_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] left_i,
  input  logic [BIT_WIDTH-1:0] right_i,
  input  logic                 c_i,
  input  logic                 present_i,
  output subpacket_t           sub_o
);

  logic [23:0] left24;
  logic [23:0] right24;
  logic        par_l;
  logic        par_r;

  assign left24  = 24'(left_i) << (24 - BIT_WIDTH);
  assign right24 = 24'(right_i) << (24 - BIT_WIDTH);
  assign par_l   = even_parity(left24, 1'b0, 1'b0, c_i);
  assign par_r   = even_parity(right24, 1'b0, 1'b0, c_i);

  // Byte order {PR,CR,UR,VR,PL,CL,UL,VL}; V and U are always zero.
  always_comb begin
    sub_o = '0;
    if (present_i) begin
      sub_o = {par_r, c_i, 1'b0, 1'b0, par_l, c_i, 1'b0, 1'b0, right24, left24};
    end
  end

endmodule

// File: rtl/audio_sample_packer.sv
// Stages up to 4 stereo samples and emits an HDMI audio sample packet on request.
// Optional macro AUDIO_CHANNEL_STATUS_EN drives C bits from a 192-bit channel-status vector.
module audio_sample_packer
  import audio_packet_pkg::*;
#(
  parameter int         BIT_WIDTH          = 16,
  parameter logic [3:0] SAMPLING_FREQUENCY = 4'b0011
) (
  input  logic                      clk_pixel,
  input  logic                      reset_n,
  input  logic [1:0][BIT_WIDTH-1:0] audio_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic                      packet_enable,
  output logic                      packet_valid,
  output logic [23:0]               header,
  output subpacket_t [3:0]          sub
);

  logic [2:0]                count_q, count_d;
  logic [7:0]                fc_q, fc_d;
  logic [3:0][BIT_WIDTH-1:0] left_q, right_q;
  logic [3:0]                b_q, c_q;
  logic                      pv_q;
  logic [23:0]               header_q;
  subpacket_t [3:0]          sub_q;

  logic                      accept;
  logic                      emit;
  logic                      c_in;
  logic [1:0]                slot;
  logic [3:0]                present;
  subpacket_t [3:0]          sub_fmt;

`ifdef AUDIO_CHANNEL_STATUS_EN
  function automatic logic [191:0] build_channel_status();
    logic [191:0] cs;
    cs        = '0;
    cs[2]     = 1'b1;
    cs[27:24] = SAMPLING_FREQUENCY;
    case (BIT_WIDTH)
      16:      cs[35:32] = 4'b0010;
      24:      cs[35:32] = 4'b1011;
      default: cs[35:32] = 4'b0000;
    endcase
    return cs;
  endfunction

  localparam logic [191:0] CHANNEL_STATUS = build_channel_status();

  assign c_in = CHANNEL_STATUS[fc_q];
`else
  assign c_in = 1'b0;
`endif

  assign sample_ready = reset_n && (count_q < 3'd4);
  assign accept       = sample_valid && sample_ready;
  assign emit         = packet_enable && (count_q != 3'd0);
  // A sample arriving alongside an emitted packet opens the next packet in slot 0.
  assign slot         = emit ? 2'd0 : count_q[1:0];

  always_comb begin
    present = '0;
    for (int i = 0; i < 4; i++) begin
      present[i] = (count_q > 3'(i));
    end
  end

  always_comb begin
    count_d = count_q + {2'b00, accept};
    if (emit) begin
      count_d = {2'b00, accept};
    end
    fc_d = fc_q;
    if (accept) begin
      fc_d = (fc_q == 8'(IEC60958_FRAME_LEN - 1)) ? 8'd0 : fc_q + 8'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_fmt
    audio_subpacket_format #(.BIT_WIDTH(BIT_WIDTH)) u_fmt (
      .left_i    (left_q[g]),
      .right_i   (right_q[g]),
      .c_i       (c_q[g]),
      .present_i (present[g]),
      .sub_o     (sub_fmt[g])
    );
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      count_q  <= '0;
      fc_q     <= '0;
      left_q   <= '0;
      right_q  <= '0;
      b_q      <= '0;
      c_q      <= '0;
      pv_q     <= 1'b0;
      header_q <= '0;
      sub_q    <= '0;
    end else begin
      count_q <= count_d;
      fc_q    <= fc_d;
      pv_q    <= emit;
      if (emit) begin
        header_q <= {b_q & present, 4'b0000, 4'b0000, present, HB0};
        sub_q    <= sub_fmt;
      end
      if (accept) begin
        left_q[slot]  <= audio_in[0];
        right_q[slot] <= audio_in[1];
        b_q[slot]     <= (fc_q == 8'd0);
        c_q[slot]     <= c_in;
      end
    end
  end

  assign packet_valid = pv_q;
  assign header       = header_q;
  assign sub          = sub_q;

endmodule

// File: doc/audio_sample_packer.md
AUDIO_SAMPLE_PACKER -- requirements
Module: audio_sample_packer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning audio sample width per channel (legal 16..24).
REQ-002 SHALL have parameter SAMPLING_FREQUENCY, default 4'b0011, meaning IEC 60958 channel-status frequency code (0011 = 32 kHz).
REQ-003 SHALL have port clk_pixel, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port audio_in, input, [BIT_WIDTH-1:0] x 2 channels, stereo sample (index 0 = left) from the sample buffer.
REQ-006 SHALL have port sample_valid, input, 1, meaning the buffer holds a sample (buffer remaining > 0).
REQ-007 SHALL have port sample_ready, output, 1, meaning the sample is consumed and the buffer removes it this cycle.
REQ-008 SHALL have port packet_enable, input, 1, single-cycle request to emit an audio sample packet.
REQ-009 SHALL have port packet_valid, output, 1, meaning header/sub hold a new packet for one cycle.
REQ-010 SHALL have port header, output, 24, HB2:HB1:HB0.
REQ-011 SHALL have port sub, output, 56 x 4, subpackets 0..3.

Function
REQ-012 SHALL stage up to 4 samples; a sample is accepted on a cycle with sample_valid && sample_ready.
REQ-013 SHALL drive sample_ready = (staged_count < 4); when full, samples stay in the buffer and none are dropped.
REQ-014 On packet_enable with staged_count > 0, SHALL register the packet and assert packet_valid exactly 1 cycle later for 1 cycle.
REQ-015 On packet_enable with staged_count == 0, SHALL emit nothing, keep packet_valid low and leave header/sub unchanged.
REQ-016 A sample accepted in the same cycle as packet_enable SHALL go to the next packet, so staged_count becomes 1, not 0.
REQ-017 header SHALL be HB0 = 8'h02; HB1 = {3'b000, layout 1'b0, sample_present[3:0]}; HB2 = {B[3:0], sample_flat 4'b0000}.
REQ-018 sample_present[i] SHALL be 1 for i < staged_count; slots are filled in order 0..3.
REQ-019 sub[i] SHALL be all-zero when sample_present[i] = 0.
REQ-020 Each sample SHALL be left-aligned into 24 bits: {sample, (24-BIT_WIDTH) zeros}.
REQ-021 sub[i][23:0] SHALL carry left, sub[i][47:24] right, and sub[i][55:48] = {PR,CR,UR,VR,PL,CL,UL,VL}.
REQ-022 V and U SHALL be 0.
REQ-023 Each P SHALL be even parity over that channel's 24 data bits plus V, U and C.
REQ-024 SHALL keep frame_counter 0..191, incremented once per accepted sample and wrapping 191 -> 0.
REQ-025 B[i] SHALL be 1 iff the slot-i sample was accepted with frame_counter == 0.
REQ-026 C for a sample SHALL be channel-status bit [frame_counter at acceptance]; both channels carry the same C.

Reset
REQ-027 While reset_n == 0 at a clock edge, SHALL clear staged_count, frame_counter, packet_valid, header and sub to 0.
REQ-028 sample_ready SHALL be 0 during reset and 1 on the first cycle after release.
REQ-029 Reset during a pending packet SHALL discard it; no packet_valid pulse follows.

Configuration
REQ-030 Macro AUDIO_CHANNEL_STATUS_EN, when defined, SHALL build a 192-bit channel-status vector: bit 2 = 1 (no copyright); bits 27:24 = SAMPLING_FREQUENCY; bits 35:32 = word length (BIT_WIDTH 16 -> 4'b0010, 24 -> 4'b1011); all other bits 0.
REQ-031 When AUDIO_CHANNEL_STATUS_EN is undefined, all C bits SHALL be 0 and the vector logic SHALL be absent.

Structure
REQ-032 Package audio_packet_pkg SHALL hold the HB0 constant 8'h02, the IEC60958_FRAME_LEN = 192 constant, the typedef subpacket_t (56 bits) and an even-parity function.
REQ-033 Sub-module audio_subpacket_format SHALL build one subpacket (alignment, VUCP byte) from two samples, C and present; it is instantiated 4 times.

Verification
REQ-034 Reset, 3 samples L=16'h1234/R=16'h5678 staged, packet_enable -> packet_valid 1 cycle later; HB1 = 8'h07; sub[0][23:0] = 24'h123400; sub[3] = 0.
REQ-035 6 samples offered with no packet_enable -> sample_ready drops after 4 accepts; next packet_enable -> HB1 = 8'h0F, then remaining 2 accepted.
REQ-036 packet_enable with 0 staged -> packet_valid stays 0, header unchanged.
REQ-037 Sample accepted in packet_enable cycle -> next packet HB1 = 8'h01 containing that sample.
REQ-038 Stream 193 samples from reset, 4 per packet -> B set only on samples 0 and 192; parity correct on every channel.
REQ-039 With AUDIO_CHANNEL_STATUS_EN, BIT_WIDTH = 16 -> C = 1 at frame_counter 2, 24, 25 and 33, all others 0; without the macro, all C = 0.
